snp_bus_arbiter: RTL and testbench



---
 rtl/snp_bus_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_snp_bus_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snp_bus_arbiter.sv
// -----------------------------------------------------------------------------
// snp_bus_arbiter
//
// Shares the single snoop-downstream channel pair (sdt request / sdr response)
// on the L2/bus side among NUM_CACHE L1 cache controllers. Requests are granted
// round-robin, and only one transaction is outstanding at a time. The winning
// request is captured into holding registers and forwarded downstream. Its
// response is routed back only to the granted cache.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_sdt_*           per-cache request channel (valid/ready, op/addr/data
//                       packed with cache i at [W*i +: W])
//   req_sdr_*           per-cache response channel (valid one-hot, rsp/data
//                       broadcast, per-cache ready)
//   sdt_*               downstream request channel to the bus-side slave
//   sdr_*               downstream response channel from the bus-side slave
//   grant_id            index of the current or most recent granted cache
//   busy                high while a transaction is in flight
//   timeout_err         one-cycle pulse when a response wait is abandoned
//
// States
//   state | meaning
//   IDLE  | pick the round-robin winner and accept its request
//   SEND  | present the held request downstream until sdt_ready
//   WAIT  | route the downstream response to the granted cache (or time out)
// -----------------------------------------------------------------------------
module snp_bus_arbiter #(
    parameter int NUM_CACHE   = 4,
    parameter int PADDR_WIDTH = 32,
    parameter int BLK_WIDTH   = 512,
    parameter int SADDR_WIDTH = PADDR_WIDTH - $clog2(BLK_WIDTH / 8),
    parameter int TIMEOUT     = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [NUM_CACHE-1:0]             req_sdt_valid,
    output logic [NUM_CACHE-1:0]             req_sdt_ready,
    input  logic [3*NUM_CACHE-1:0]           req_sdt_op,
    input  logic [SADDR_WIDTH*NUM_CACHE-1:0] req_sdt_addr,
    input  logic [BLK_WIDTH*NUM_CACHE-1:0]   req_sdt_data,

    output logic [NUM_CACHE-1:0]             req_sdr_valid,
    input  logic [NUM_CACHE-1:0]             req_sdr_ready,
    output logic [2:0]                       req_sdr_rsp,
    output logic [BLK_WIDTH-1:0]             req_sdr_data,

    output logic                             sdt_valid,
    input  logic                             sdt_ready,
    output logic [2:0]                       sdt_op,
    output logic [SADDR_WIDTH-1:0]           sdt_addr,
    output logic [BLK_WIDTH-1:0]             sdt_data,

    input  logic                             sdr_valid,
    output logic                             sdr_ready,
    input  logic [2:0]                       sdr_rsp,
    input  logic [BLK_WIDTH-1:0]             sdr_data,

    output logic [$clog2(NUM_CACHE)-1:0]     grant_id,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam int GW = $clog2(NUM_CACHE);
    // Counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [GW-1:0]          ptr;
    logic [GW-1:0]          grant_q;
    logic [CW-1:0]          cnt;

    logic [2:0]             op_q;
    logic [SADDR_WIDTH-1:0] addr_q;
    logic [BLK_WIDTH-1:0]   data_q;

    logic [GW-1:0]          winner;
    logic                   any_valid;
    int                     idx;

    logic [2:0]             win_op;
    logic [SADDR_WIDTH-1:0] win_addr;
    logic [BLK_WIDTH-1:0]   win_data;

    logic                   accept;
    logic                   sdr_hs;
    logic                   tmo_hit;
    logic                   done;
    logic [GW-1:0]          grant_inc;

    // Round-robin search starting at ptr. Scanning from the far end downwards
    // lets the closest valid requester (smallest offset from ptr) win.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_CACHE - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CACHE;
            if (req_sdt_valid[idx]) begin
                winner    = GW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        win_op   = req_sdt_op[3*int'(winner) +: 3];
        win_addr = req_sdt_addr[SADDR_WIDTH*int'(winner) +: SADDR_WIDTH];
        win_data = req_sdt_data[BLK_WIDTH*int'(winner) +: BLK_WIDTH];
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt     = state;
        req_sdt_ready = '0;
        req_sdr_valid = '0;
        sdt_valid     = 1'b0;
        sdr_ready     = 1'b0;
        accept        = 1'b0;
        sdr_hs        = 1'b0;
        tmo_hit       = 1'b0;

        case (state)
            IDLE: begin
                // rst_n gating keeps ready low while reset is held with
                // requests already pending.
                if (any_valid && rst_n) begin
                    req_sdt_ready[winner] = 1'b1;
                    accept                = 1'b1;
                    state_nxt             = SEND;
                end
            end
            SEND: begin
                sdt_valid = 1'b1;
                if (sdt_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                req_sdr_valid[grant_q] = sdr_valid;
                sdr_ready              = req_sdr_ready[grant_q];
                sdr_hs                 = sdr_valid && req_sdr_ready[grant_q];
                tmo_hit                = !sdr_hs && (TIMEOUT != 0) &&
                                         (int'(cnt) == TIMEOUT - 1);
                if (sdr_hs || tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign done      = sdr_hs || tmo_hit;
    assign grant_inc = (int'(grant_q) == NUM_CACHE - 1) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_q     <= '0;
            cnt         <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= tmo_hit;

            if (accept) begin
                op_q    <= win_op;
                addr_q  <= win_addr;
                data_q  <= win_data;
                grant_q <= winner;
            end

            // Pointer only moves when a transaction finishes, so a waiting
            // requester is reached within NUM_CACHE transactions.
            if (done) begin
                ptr <= grant_inc;
            end

            // Counter is zero on the first WAIT cycle and counts WAIT cycles.
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    // Payloads are forced to zero outside the state that owns them.
    assign sdt_op       = (state == SEND) ? op_q   : '0;
    assign sdt_addr     = (state == SEND) ? addr_q : '0;
    assign sdt_data     = (state == SEND) ? data_q : '0;
    assign req_sdr_rsp  = (state == WAIT) ? sdr_rsp  : '0;
    assign req_sdr_data = (state == WAIT) ? sdr_data : '0;

    assign grant_id = grant_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_snp_bus_arbiter.sv
module tb_snp_bus_arbiter;

    localparam int NC = 4;
    localparam int PW = 32;
    localparam int BW = 64;
    localparam int SW = PW - $clog2(BW / 8);
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     req_sdt_valid;
    logic [NC-1:0]     req_sdt_ready;
    logic [3*NC-1:0]   req_sdt_op;
    logic [SW*NC-1:0]  req_sdt_addr;
    logic [BW*NC-1:0]  req_sdt_data;
    logic [NC-1:0]     req_sdr_valid;
    logic [NC-1:0]     req_sdr_ready;
    logic [2:0]        req_sdr_rsp;
    logic [BW-1:0]     req_sdr_data;
    logic              sdt_valid;
    logic              sdt_ready;
    logic [2:0]        sdt_op;
    logic [SW-1:0]     sdt_addr;
    logic [BW-1:0]     sdt_data;
    logic              sdr_valid;
    logic              sdr_ready;
    logic [2:0]        sdr_rsp;
    logic [BW-1:0]     sdr_data;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;   // reference round-robin pointer

    always #5 clk = ~clk;

    snp_bus_arbiter #(
        .NUM_CACHE   (NC),
        .PADDR_WIDTH (PW),
        .BLK_WIDTH   (BW),
        .SADDR_WIDTH (SW),
        .TIMEOUT     (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_sdt_valid (req_sdt_valid),
        .req_sdt_ready (req_sdt_ready),
        .req_sdt_op    (req_sdt_op),
        .req_sdt_addr  (req_sdt_addr),
        .req_sdt_data  (req_sdt_data),
        .req_sdr_valid (req_sdr_valid),
        .req_sdr_ready (req_sdr_ready),
        .req_sdr_rsp   (req_sdr_rsp),
        .req_sdr_data  (req_sdr_data),
        .sdt_valid     (sdt_valid),
        .sdt_ready     (sdt_ready),
        .sdt_op        (sdt_op),
        .sdt_addr      (sdt_addr),
        .sdt_data      (sdt_data),
        .sdr_valid     (sdr_valid),
        .sdr_ready     (sdr_ready),
        .sdr_rsp       (sdr_rsp),
        .sdr_data      (sdr_data),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    // Reference arbitration: first requester found walking from m_ptr.
    function automatic int model_pick(input logic [NC-1:0] mask);
        for (int k = 0; k < NC; k++) begin
            if (mask[(m_ptr + k) % NC]) return (m_ptr + k) % NC;
        end
        return -1;
    endfunction

    task automatic rand_payload();
        for (int i = 0; i < NC; i++) begin
            req_sdt_op[3*i +: 3]     = 3'($urandom);
            req_sdt_addr[SW*i +: SW] = SW'($urandom);
            req_sdt_data[BW*i +: BW] = {$urandom, $urandom};
        end
    endtask

    task automatic idle_inputs();
        req_sdt_valid = '0;
        sdt_ready     = 1'b0;
        sdr_valid     = 1'b0;
        req_sdr_ready = '0;
        sdr_rsp       = '0;
        sdr_data      = '0;
    endtask

    // One full transaction. Entered and left at posedge+1 of an IDLE cycle.
    task automatic run_txn(input logic [NC-1:0] mask, input int sdt_dly,
                           input int sdr_dly, input int rdy_dly, input bit keep,
                           input int rsp, output int seen);
        int            win;
        int            last;
        logic [2:0]    e_op;
        logic [SW-1:0] e_addr;
        logic [BW-1:0] e_data;
        logic [NC-1:0] rdy;
        logic [NC-1:0] e_onehot;
        if (!keep) rand_payload();
        req_sdt_valid = mask;
        win      = model_pick(mask);
        e_onehot = NC'(1 << win);
        e_op     = req_sdt_op[3*win +: 3];
        e_addr   = req_sdt_addr[SW*win +: SW];
        e_data   = req_sdt_data[BW*win +: BW];
        seen     = -1;
        @(negedge clk);
        checks++;
        if (req_sdt_ready !== e_onehot)
            $display("FAIL idle_ready got %b want %b", req_sdt_ready, e_onehot);
        checks++;
        if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy);
        if (req_sdt_ready !== e_onehot || busy !== 1'b0) errors++;
        @(posedge clk); #1;
        rand_payload();  // holding registers must decouple the inputs
        for (int c = 0; c <= sdt_dly; c++) begin
            sdt_ready = (c == sdt_dly);
            @(negedge clk);
            checks++;
            if ({sdt_valid, sdt_op, sdt_addr, sdt_data} !== {1'b1, e_op, e_addr, e_data}) begin
                errors++;
                $display("FAIL sdt_payload got v=%b op=%h a=%h d=%h want v=1 op=%h a=%h d=%h",
                         sdt_valid, sdt_op, sdt_addr, sdt_data, e_op, e_addr, e_data);
            end
            checks++;
            if (req_sdt_ready !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL send_ready_busy got rdy=%b busy=%b want rdy=0 busy=1",
                         req_sdt_ready, busy);
            end
            checks++;
            if (int'(grant_id) !== win) begin
                errors++;
                $display("FAIL grant_id got %0d want %0d", grant_id, win);
            end
            if (c == 0) seen = int'(grant_id);
            @(posedge clk); #1;
        end
        sdt_ready = 1'b0;
        last = sdr_dly + rdy_dly;
        for (int c = 0; c <= last; c++) begin
            sdr_valid     = (c >= sdr_dly);
            sdr_rsp       = (rsp < 0) ? 3'($urandom) : 3'(rsp);
            sdr_data      = {$urandom, $urandom};
            rdy           = NC'($urandom);
            rdy[win]      = (c == last);
            req_sdr_ready = rdy;
            @(negedge clk);
            checks++;
            if (req_sdr_valid !== (sdr_valid ? e_onehot : '0)) begin
                errors++;
                $display("FAIL sdr_route got %b want %b", req_sdr_valid,
                         sdr_valid ? e_onehot : '0);
            end
            checks++;
            if (sdr_ready !== rdy[win]) begin
                errors++;
                $display("FAIL sdr_ready got %b want %b", sdr_ready, rdy[win]);
            end
            checks++;
            if (req_sdr_rsp !== sdr_rsp || req_sdr_data !== sdr_data) begin
                errors++;
                $display("FAIL sdr_pass got %h/%h want %h/%h", req_sdr_rsp, req_sdr_data,
                         sdr_rsp, sdr_data);
            end
            checks++;
            if (sdt_valid !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL wait_status got sdt_valid=%b tmo=%b busy=%b want 0 0 1",
                         sdt_valid, timeout_err, busy);
            end
            @(posedge clk); #1;
        end
        sdr_valid     = 1'b0;
        req_sdr_ready = '0;
        m_ptr         = (win + 1) % NC;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        rand_payload();
        req_sdt_valid = '1;
        sdt_ready     = 1'b1;
        sdr_valid     = 1'b1;
        sdr_rsp       = 3'b111;
        sdr_data      = '1;
        req_sdr_ready = '1;
        #3;
        checks++;
        if ({req_sdt_ready, req_sdr_valid, sdt_valid, sdt_op, sdt_addr, sdt_data, sdr_ready,
             busy, timeout_err, req_sdr_rsp, req_sdr_data, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b rv=%b sv=%b sr=%b busy=%b gid=%0d rsp=%h",
                     req_sdt_ready, req_sdr_valid, sdt_valid, sdr_ready, busy, grant_id,
                     req_sdr_rsp);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_sdt_ready !== '0 || busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_idle got rdy=%b busy=%b gid=%0d want 0 0 0",
                     req_sdt_ready, busy, grant_id);
        end
        @(posedge clk); #1;
        m_ptr = 0;
    endtask

    task automatic test_all_valid();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int seen;
        for (int i = 0; i < 5; i++) begin
            run_txn(4'hF, 0, 0, 0, 1'b0, -1, seen);
            checks++;
            if (seen !== exp_order[i]) begin
                errors++;
                $display("FAIL rr_order[%0d] got %0d want %0d", i, seen, exp_order[i]);
            end
        end
    endtask

    task automatic test_single();
        int seen;
        rand_payload();
        req_sdt_op[3*2 +: 3]    = 3'b001;
        req_sdt_addr[SW*2 +: SW] = SW'(32'h123);
        run_txn(4'b0100, 0, 1, 0, 1'b1, 2, seen);
        checks++;
        if (seen !== 2) begin
            errors++;
            $display("FAIL single_grant got %0d want 2", seen);
        end
    endtask

    task automatic test_wrap();
        int seen;
        // pointer is now 3 after serving cache 2
        run_txn(4'b0010, 0, 0, 0, 1'b0, -1, seen);
        checks++;
        if (seen !== 1) begin
            errors++;
            $display("FAIL wrap_grant got %0d want 1", seen);
        end
        run_txn(4'b1111, 0, 0, 0, 1'b0, -1, seen);
        checks++;
        if (seen !== 2) begin
            errors++;
            $display("FAIL wrap_next got %0d want 2", seen);
        end
    endtask

    task automatic test_backpressure();
        int seen;
        run_txn(4'hF, 5, 0, 3, 1'b0, -1, seen);
        run_txn(4'b1001, 5, 2, 3, 1'b0, -1, seen);
    endtask

    task automatic test_back_to_back();
        int seen;
        for (int i = 0; i < 6; i++) run_txn(4'hF, 0, 0, 0, 1'b0, -1, seen);
    endtask

    task automatic test_random();
        int seen;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_sdt_valid = '0;
                @(negedge clk);
                checks++;
                if (req_sdt_ready !== '0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_no_req got rdy=%b busy=%b want 0 0", req_sdt_ready, busy);
                end
                @(posedge clk); #1;
            end
            run_txn(NC'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom_range(0, 6),
                    $urandom_range(0, 4), 1'b0, -1, seen);
        end
    endtask

    task automatic test_timeout();
        int win;
        int seen;
        rand_payload();
        req_sdt_valid = NC'($urandom_range(1, 15));
        win = model_pick(req_sdt_valid);
        @(posedge clk); #1;
        sdt_ready = 1'b1;
        @(posedge clk); #1;
        sdt_ready     = 1'b0;
        req_sdt_valid = '0;
        for (int c = 0; c <= TO + 1; c++) begin
            sdr_valid     = (c == TO);
            req_sdr_ready = (c == TO) ? '1 : '0;
            @(negedge clk);
            checks++;
            if (timeout_err !== (c == TO)) begin
                errors++;
                $display("FAIL timeout_pulse cycle %0d got %b want %b", c, timeout_err, (c == TO));
            end
            checks++;
            if (busy !== (c < TO)) begin
                errors++;
                $display("FAIL timeout_busy cycle %0d got %b want %b", c, busy, (c < TO));
            end
            if (c == TO) begin
                checks++;
                if (sdr_ready !== 1'b0 || req_sdr_valid !== '0) begin
                    errors++;
                    $display("FAIL late_rsp got sdr_ready=%b rv=%b want 0 0", sdr_ready,
                             req_sdr_valid);
                end
            end
            @(posedge clk); #1;
        end
        sdr_valid     = 1'b0;
        req_sdr_ready = '0;
        m_ptr = (win + 1) % NC;
        run_txn(4'hF, 0, 0, 0, 1'b0, -1, seen);
        checks++;
        if (seen !== (win + 1) % NC) begin
            errors++;
            $display("FAIL after_timeout_grant got %0d want %0d", seen, (win + 1) % NC);
        end
    endtask

    task automatic test_reset_in_wait();
        int            win;
        int            seen;
        logic [NC-1:0] e_onehot;
        rand_payload();
        req_sdt_valid = 4'hF;
        win      = model_pick(4'hF);
        e_onehot = NC'(1 << win);
        @(posedge clk); #1;
        sdt_ready = 1'b1;
        @(posedge clk); #1;
        sdt_ready     = 1'b0;
        sdr_valid     = 1'b1;
        sdr_rsp       = 3'b101;
        sdr_data      = {$urandom, $urandom};
        req_sdr_ready = '0;
        @(negedge clk);
        checks++;
        if (req_sdr_valid !== e_onehot) begin
            errors++;
            $display("FAIL pre_reset_route got %b want %b", req_sdr_valid, e_onehot);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_sdt_ready, req_sdr_valid, sdt_valid, sdt_op, sdt_addr, sdt_data, sdr_ready,
             busy, timeout_err, req_sdr_rsp, req_sdr_data, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_in_wait got rdy=%b rv=%b sv=%b sr=%b busy=%b gid=%0d rsp=%h",
                     req_sdt_ready, req_sdr_valid, sdt_valid, sdr_ready, busy, grant_id,
                     req_sdr_rsp);
        end
        @(posedge clk); #1;
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_ptr = 0;
        run_txn(4'b1110, 0, 0, 0, 1'b0, -1, seen);
        checks++;
        if (seen !== 1) begin
            errors++;
            $display("FAIL reset_first_grant got %0d want 1", seen);
        end
    endtask

    initial begin
        idle_inputs();
        req_sdt_op   = '0;
        req_sdt_addr = '0;
        req_sdt_data = '0;
        test_reset();
        test_all_valid();
        test_single();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
